// File: rtl/code_serializer.sv
`default_nettype none
// ============================================================================
// Module  : code_serializer
// Purpose : Serializes a nonzero 8-bit code MSB-first as an on-off keyed line,
//           followed by a forced-low inter-frame gap.
// Revision: 1.0 - initial release
// ============================================================================
module code_serializer #(
  parameter int CLKS_PER_BIT = 50000,
  parameter int GAP_BITS     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code,
  output logic       tx_bit,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int CYC_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int BIT_W   = $clog2(BIT_MAX);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_data = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;

  localparam logic [CYC_W-1:0] c_cyc_last = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [CYC_W-1:0] c_cyc_pen  = CYC_W'(CLKS_PER_BIT - 2);
  localparam logic [CYC_W-1:0] c_cyc_one  = CYC_W'(1);
  localparam logic [BIT_W-1:0] c_bit_data = BIT_W'(7);
  localparam logic [BIT_W-1:0] c_bit_gap  = BIT_W'(GAP_BITS - 1);
  localparam logic [BIT_W-1:0] c_bit_one  = BIT_W'(1);

  logic [1:0]       r_state;
  logic [7:0]       r_shift;
  logic [CYC_W-1:0] r_cyc;
  logic [BIT_W-1:0] r_bit;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_count;

  logic w_cyc_last;
  logic w_gap_last_bit;

  assign w_cyc_last     = (r_cyc == c_cyc_last);
  assign w_gap_last_bit = (r_bit == c_bit_gap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_shift <= 8'h00;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (code != 8'h00) begin
            r_shift <= code;
            r_tx    <= code[7];
            r_busy  <= 1'b1;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_state <= c_st_data;
          end
        end
        c_st_data: begin
          if (w_cyc_last) begin
            r_cyc <= '0;
            if (r_bit == c_bit_data) begin
              r_bit   <= '0;
              r_tx    <= 1'b0;
              r_state <= c_st_gap;
            end else begin
              // Rotate so the next bit to send always sits at position 7.
              r_bit   <= r_bit + c_bit_one;
              r_shift <= {r_shift[6:0], r_shift[7]};
              r_tx    <= r_shift[6];
            end
          end else begin
            r_cyc <= r_cyc + c_cyc_one;
          end
        end
        c_st_gap: begin
          if (w_cyc_last) begin
            r_cyc <= '0;
            if (w_gap_last_bit) begin
              r_bit   <= '0;
              r_busy  <= 1'b0;
              r_count <= r_count + 8'd1;
              r_state <= c_st_idle;
            end else begin
              r_bit <= r_bit + c_bit_one;
            end
          end else begin
            // Raise the pulse one cycle early so it is registered on the final gap cycle.
            r_cyc  <= r_cyc + c_cyc_one;
            r_done <= w_gap_last_bit && (r_cyc == c_cyc_pen);
          end
        end
        default: begin
          r_state <= c_st_idle;
          r_tx    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_bit      = r_tx;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign frame_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_code_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_code_serializer
// Purpose : Randomized scoreboard bench for code_serializer (CLKS_PER_BIT=4,
//           GAP_BITS=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_code_serializer;

  localparam int CPB       = 4;
  localparam int GAP       = 2;
  localparam int FRAME_LEN = (8 + GAP) * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code = 8'h00;
  logic       tx_bit;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  int total = 0;
  int bad   = 0;

  code_serializer #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .tx_bit(tx_bit),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a busy window of FRAME_LEN cycles; nonzero code
  // starts one whenever no window is open.
  logic [7:0] exp_q[$];
  int         m_left = 0;
  logic [7:0] m_count = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_count <= 8'h00;
      exp_q.delete();
    end else if (m_left == 0) begin
      if (code != 8'h00) begin
        exp_q.push_back(code);
        m_left <= FRAME_LEN;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) m_count <= m_count + 8'd1;
    end
  end

  function automatic logic [FRAME_LEN-1:0] exp_frame(input logic [7:0] v);
    logic [FRAME_LEN-1:0] e;
    e = '0;
    for (int c = 0; c < 8 * CPB; c++) e[FRAME_LEN-1-c] = v[7 - c / CPB];
    return e;
  endfunction

  // Monitor: captures each busy window and compares against the popped code.
  logic                 in_frame = 1'b0;
  int                   idx = 0;
  logic [7:0]           cur = 8'h00;
  logic [FRAME_LEN-1:0] cap = '0;
  logic [FRAME_LEN-1:0] dcap = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else begin
        chk("busy_vs_model", busy, (m_left != 0));
        if (in_frame && busy) begin
          if (idx < FRAME_LEN) begin
            cap[FRAME_LEN-1-idx]  = tx_bit;
            dcap[FRAME_LEN-1-idx] = frame_done;
          end
          idx++;
        end else if (in_frame) begin
          chk("frame_len", idx, FRAME_LEN);
          chk("frame_tx", cap, exp_frame(cur));
          chk("frame_done_pos", dcap, 1);
          chk("frame_count", frame_count, m_count);
          chk("idle_tx_after", tx_bit, 0);
          in_frame = 1'b0;
        end else if (busy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            cur = 8'h00;
          end else begin
            cur = exp_q.pop_front();
          end
          in_frame = 1'b1;
          cap  = '0;
          dcap = '0;
          cap[FRAME_LEN-1]  = tx_bit;
          dcap[FRAME_LEN-1] = frame_done;
          idx = 1;
        end else begin
          chk("idle_outputs", {tx_bit, frame_done}, 2'b00);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || m_left != 0) && k < 4 * FRAME_LEN) begin
      tick(1);
      k++;
    end
    tick(2);
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    code  = 8'h00;
    tick(3);
    chk("rst_tx", tx_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_count", frame_count, 0);
    rst_n = 1'b1;

    // No requests: line must stay quiet
    tick(100);
    chk("quiet_count", frame_count, 0);

    // Single pulse A0
    code = 8'hA0;
    tick(1);
    code = 8'h00;
    wait_idle();
    chk("a0_count", frame_count, 1);

    // Held AA for exactly three frames
    code = 8'hAA;
    tick(2 * (FRAME_LEN + 1) + 5);
    code = 8'h00;
    wait_idle();
    chk("aa_count", frame_count, 4);

    // 80 latched, code changes mid-frame
    code = 8'h80;
    tick(5);
    code = 8'hAA;
    tick(30);
    code = 8'h00;
    wait_idle();
    chk("ignore_count", frame_count, 5);

    // Randomized codes and hold times
    for (int i = 0; i < 20; i++) begin
      code = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      tick($urandom_range(1, 60));
      code = 8'h00;
      tick($urandom_range(0, 5));
    end
    wait_idle();

    // Asynchronous reset mid-frame
    code = 8'hFF;
    tick(10);
    code = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("amid_tx", tx_bit, 0);
    chk("amid_busy", busy, 0);
    chk("amid_done", frame_done, 0);
    chk("amid_count", frame_count, 0);
    tick(2);
    #2 rst_n = 1'b1;
    tick(20);
    chk("after_rst_count", frame_count, 0);

    // 256 back-to-back FF frames wrap the counter
    code = 8'hFF;
    tick(255 * (FRAME_LEN + 1) + 3);
    code = 8'h00;
    wait_idle();
    chk("wrap_count", frame_count, 0);
    chk("wrap_model", m_count, 0);

    chk("queue_empty", exp_q.size(), 0);
    chk("monitor_idle", in_frame, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
